dl_router: RTL and testbench

DL_ROUTER -- requirements
Module: dl_router

---
 rtl/dl_router_if.sv | 22 ++
 rtl/dl_router.sv | 184 ++++++++++++++++++
 tb/tb_dl_router.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl_router_if.sv
// rtl/dl_router_if.sv - SDRAM write-port bundle between the download router and the SDRAM controller
// One toggle-handshake write port per SDRAM client; the router is master, the controller is slave.
interface dl_router_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]    port_req;
  logic [NPORTS-1:0]    port_ack;
  logic [NPORTS*23-1:0] port_a;
  logic [NPORTS*2-1:0]  port_ds;
  logic [NPORTS*16-1:0] port_d;
  logic [NPORTS-1:0]    port_we;

  modport master (
    output port_req, port_a, port_ds, port_d, port_we,
    input  port_ack
  );

  modport slave (
    input  port_req, port_a, port_ds, port_d, port_we,
    output port_ack
  );
endinterface

// File: rtl/dl_router.sv
// rtl/dl_router.sv - routes ioctl download bytes into per-region SDRAM write ports, with load/reset sequencing
// Optional running byte checksum is built only when DL_ROUTER_CHECKSUM_EN is defined.
module dl_router #(
  parameter int                   NPORTS    = 2,
  parameter int                   DEPTH     = 4,
  parameter logic [NPORTS*25-1:0] PORT_BASE = {25'h10000, 25'h00000},
  parameter logic [NPORTS*25-1:0] PORT_END  = {25'h28000, 25'h28200},
  parameter int                   HOLD      = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  dl_router_if.master sdram,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow,
  output logic [15:0] checksum
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]     HOLD_CNT = 8'(HOLD);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nx;

  logic [24:0]       addr_mem [DEPTH];
  logic [7:0]        data_mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              wr_q, downl_q, dl_ended;
  logic [NPORTS-1:0] hit_q;
  logic [7:0]        hold_cnt;

  logic              push_req, push, pop, issue, acked;
  logic              fifo_full, fifo_empty, downl_rise, rom_set;
  logic [NPORTS-1:0] in_hit, head_hit;
  logic [24:0]       head_addr;
  logic [7:0]        head_data;
  logic [23:0]       off [NPORTS];

  function automatic logic [NPORTS-1:0] hit_mask(input logic [24:0] addr);
    logic [NPORTS-1:0] m;
    m = '0;
    for (int i = 0; i < NPORTS; i++)
      m[i] = (addr >= PORT_BASE[i*25 +: 25]) && (addr < PORT_END[i*25 +: 25]);
    return m;
  endfunction

  assign in_hit     = hit_mask(ioctl_addr);
  assign push_req   = ioctl_downl & ioctl_wr & ~wr_q & (|in_hit);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = push_req & ~fifo_full;
  assign downl_rise = ioctl_downl & ~downl_q;

  assign head_addr = addr_mem[rptr];
  assign head_data = data_mem[rptr];
  assign head_hit  = hit_mask(head_addr);

  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      off[i] = 24'(head_addr - PORT_BASE[i*25 +: 25]);
  end

  // A port is done once its ack has caught up with its req; ports not hit by this entry are ignored.
  assign acked = &(~hit_q | ~(sdram.port_req ^ sdram.port_ack));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    pop      = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) begin
                 state_nx = S_ISSUE;
                 issue    = 1'b1;
               end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (acked) begin
                 state_nx = S_IDLE;
                 pop      = 1'b1;
               end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      addr_mem[wptr] <= ioctl_addr;
      data_mem[wptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Port outputs are loaded on the IDLE->ISSUE transition so the req toggle is visible while in ISSUE.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sdram.port_req <= '0;
      sdram.port_a   <= '0;
      sdram.port_ds  <= '0;
      sdram.port_d   <= '0;
      hit_q          <= '0;
    end else if (issue) begin
      hit_q <= head_hit;
      for (int i = 0; i < NPORTS; i++) begin
        if (head_hit[i]) begin
          sdram.port_a[i*23 +: 23]  <= off[i][23:1];
          sdram.port_ds[i*2 +: 2]   <= {off[i][0], ~off[i][0]};
          sdram.port_d[i*16 +: 16]  <= {head_data, head_data};
          sdram.port_req[i]         <= ~sdram.port_req[i];
        end
      end
    end
  end

  assign sdram.port_we = {NPORTS{ioctl_downl | (state != S_IDLE) | ~fifo_empty}};

  // downl_q still high means the download ended this very cycle.
  assign rom_set = ~ioctl_downl & (dl_ended | downl_q) & fifo_empty &
                   (state == S_IDLE) & ~rom_loaded;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      dl_ended   <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
      if (downl_q && !ioctl_downl) dl_ended <= 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (downl_rise)       overflow <= 1'b0;
      if (downl_rise)   rom_loaded <= 1'b0;
      else if (rom_set) rom_loaded <= 1'b1;
      if (rom_set)              hold_cnt <= HOLD_CNT;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
      core_reset <= ext_reset | ~rom_loaded | (hold_cnt != '0);
    end
  end

`ifdef DL_ROUTER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)        sum_q <= '0;
    else if (downl_rise) sum_q <= push ? {8'h00, ioctl_dout} : 16'h0000;
    else if (push)       sum_q <= sum_q + {8'h00, ioctl_dout};
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dl_router.sv
// tb/tb_dl_router.sv - self-checking bench for dl_router against a byte-level region/handshake model
module tb_dl_router;
  localparam int NPORTS = 2;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 16;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic        clk_sys, reset_n;
  logic        ioctl_downl, ioctl_wr, ext_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_loaded, core_reset, overflow;
  logic [15:0] checksum;

  dl_router_if #(.NPORTS(NPORTS)) bus ();

  dl_router #(.NPORTS(NPORTS), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ioctl_downl(ioctl_downl),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ext_reset  (ext_reset),
    .sdram      (bus.master),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int     n_cmp, n_bad;
  wr_t    exp_q [NPORTS][$];
  wr_t    obs_q [NPORTS][$];
  longint stamp_q [NPORTS][$];
  int     exp_sum;
  bit     ack_en;
  int     ack_dly;
  bit     pend [NPORTS];
  int     cnt [NPORTS];
  longint cyc;

  function automatic logic [24:0] base_of(int i);
    return (i == 0) ? 25'h00000 : 25'h10000;
  endfunction

  function automatic logic [24:0] end_of(int i);
    return (i == 0) ? 25'h28200 : 25'h28000;
  endfunction

  // SDRAM controller stand-in: logs each request when first seen, acks after ack_dly cycles.
  always @(negedge clk_sys) begin
    cyc++;
    for (int i = 0; i < NPORTS; i++) begin
      if (!reset_n) begin
        bus.port_ack[i] = 1'b0;
        pend[i] = 1'b0;
        cnt[i]  = 0;
      end else if (bus.port_req[i] != bus.port_ack[i]) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          cnt[i]  = 0;
          obs_q[i].push_back('{a: bus.port_a[i*23 +: 23], ds: bus.port_ds[i*2 +: 2],
                               d: bus.port_d[i*16 +: 16]});
          stamp_q[i].push_back(cyc);
        end
        if (ack_en) begin
          if (cnt[i] >= ack_dly) begin
            bus.port_ack[i] = bus.port_req[i];
            pend[i] = 1'b0;
          end else cnt[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < NPORTS; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
      stamp_q[i].delete();
    end
  endtask

  task automatic model_push(input logic [24:0] addr, input logic [7:0] data);
    bit any;
    int off;
    any = 0;
    for (int i = 0; i < NPORTS; i++) begin
      if (addr >= base_of(i) && addr < end_of(i)) begin
        off = int'(addr - base_of(i));
        exp_q[i].push_back('{a: 23'(off / 2), ds: (off % 2 == 1) ? 2'b10 : 2'b01, d: {data, data}});
        any = 1;
      end
    end
    if (any) exp_sum = (exp_sum + int'(data)) % 65536;
  endtask

  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data, input bit record);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
    if (record) model_push(addr, data);
  endtask

  task automatic start_dl();
    ioctl_downl = 1'b1;
    exp_sum = 0;
    tick();
  endtask

  task automatic end_dl();
    ioctl_downl = 1'b0;
    tick();
  endtask

  task automatic wait_drain(output bit ok);
    bit done;
    ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      tick();
      done = 1;
      for (int i = 0; i < NPORTS; i++)
        if (obs_q[i].size() != exp_q[i].size() || pend[i]) done = 0;
      ok = done;
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    ext_reset   = 1'b0;
    repeat (2) tick();
    clear_log();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.port_req !== 2'b00) begin n_bad++; $display("FAIL reset_req: got %b want 00", bus.port_req); end
    n_cmp++; if ({bus.port_a, bus.port_ds, bus.port_d} !== '0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {bus.port_a, bus.port_ds, bus.port_d}); end
    n_cmp++; if ({overflow, rom_loaded, core_reset} !== 3'b001) begin n_bad++; $display("FAIL reset_flags: got %b want 001", {overflow, rom_loaded, core_reset}); end
    n_cmp++; if (checksum !== 16'h0) begin n_bad++; $display("FAIL reset_checksum: got %h want 0000", checksum); end
    n_cmp++; if (bus.port_we !== 2'b00) begin n_bad++; $display("FAIL reset_we: got %b want 00", bus.port_we); end
  endtask

  task automatic test_directed();
    bit ok;
    clear_log();
    ack_en = 1; ack_dly = 3;
    start_dl();
    n_cmp++; if (bus.port_we !== 2'b11) begin n_bad++; $display("FAIL dl_we: got %b want 11", bus.port_we); end
    ioctl_addr = 25'h00000; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n_cmp++; if (bus.port_req !== 2'b00) begin n_bad++; $display("FAIL lat_early: got %b want 00", bus.port_req); end
    tick();
    n_cmp++; if (bus.port_req !== 2'b01) begin n_bad++; $display("FAIL lat_n2: got %b want 01", bus.port_req); end
    model_push(25'h00000, 8'h11);
    wr_byte(25'h10001, 8'h22, 1);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dir_drain: got timeout want drained"); end
    for (int i = 0; i < NPORTS; i++) begin
      n_cmp++; if (obs_q[i].size() !== exp_q[i].size()) begin n_bad++; $display("FAIL dir_count p%0d: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      for (int j = 0; j < obs_q[i].size() && j < exp_q[i].size(); j++) begin
        n_cmp++; if (obs_q[i][j] !== exp_q[i][j]) begin n_bad++; $display("FAIL dir_data p%0d[%0d]: got %h want %h", i, j, obs_q[i][j], exp_q[i][j]); end
      end
    end
    if (stamp_q[0].size() == 2 && stamp_q[1].size() == 1) begin
      n_cmp++; if (stamp_q[0][1] !== stamp_q[1][0]) begin n_bad++; $display("FAIL dir_same_hs: got %0d want %0d", stamp_q[1][0], stamp_q[0][1]); end
    end
  endtask

  task automatic test_regions();
    bit ok;
    logic [24:0] addrs [6];
    clear_log();
    addrs = '{25'h28100, 25'h30000, 25'h281FF, 25'h28200, 25'h27FFF, 25'h28000};
    foreach (addrs[k]) wr_byte(addrs[k], 8'(8'hA0 + k), 1);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reg_drain: got timeout want drained"); end
    for (int i = 0; i < NPORTS; i++) begin
      n_cmp++; if (obs_q[i].size() !== exp_q[i].size()) begin n_bad++; $display("FAIL reg_count p%0d: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      for (int j = 0; j < obs_q[i].size() && j < exp_q[i].size(); j++) begin
        n_cmp++; if (obs_q[i][j] !== exp_q[i][j]) begin n_bad++; $display("FAIL reg_data p%0d[%0d]: got %h want %h", i, j, obs_q[i][j], exp_q[i][j]); end
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reg_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_random();
    bit ok;
    logic [24:0] edges [8];
    logic [24:0] a;
    edges = '{25'h00000, 25'h0FFFF, 25'h10000, 25'h27FFF, 25'h28000, 25'h281FF, 25'h28200, 25'h2FFFF};
    clear_log();
    for (int b = 0; b < 8; b++) begin
      ack_dly = $urandom_range(0, 4);
      for (int k = 0; k < int'($urandom_range(1, DEPTH)); k++) begin
        if ($urandom_range(0, 3) == 0) a = edges[$urandom_range(0, 7)];
        else a = 25'($urandom_range(0, 32'h2FFFF));
        wr_byte(a, 8'($urandom), 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_drain b%0d: got timeout want drained", b); end
    end
    for (int i = 0; i < NPORTS; i++) begin
      n_cmp++; if (obs_q[i].size() !== exp_q[i].size()) begin n_bad++; $display("FAIL rand_count p%0d: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      for (int j = 0; j < obs_q[i].size() && j < exp_q[i].size(); j++) begin
        n_cmp++; if (obs_q[i][j] !== exp_q[i][j]) begin n_bad++; $display("FAIL rand_data p%0d[%0d]: got %h want %h", i, j, obs_q[i][j], exp_q[i][j]); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    end_dl();
    clear_log();
    ack_en = 0; ack_dly = 1;
    start_dl();
    for (int k = 0; k < 6; k++) begin
      wr_byte(25'h00100 + 25'(k), 8'(8'h30 + k), k < DEPTH);
      if (k == DEPTH - 1) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
      end
      if (k == DEPTH) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
      end
    end
    n_cmp++; if (obs_q[0].size() !== 1) begin n_bad++; $display("FAIL ovf_held: got %0d want 1", obs_q[0].size()); end
    ack_en = 1;
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_drain: got timeout want drained"); end
    n_cmp++; if (obs_q[0].size() !== DEPTH) begin n_bad++; $display("FAIL ovf_hs: got %0d want %0d", obs_q[0].size(), DEPTH); end
    for (int j = 0; j < obs_q[0].size() && j < exp_q[0].size(); j++) begin
      n_cmp++; if (obs_q[0][j] !== exp_q[0][j]) begin n_bad++; $display("FAIL ovf_data [%0d]: got %h want %h", j, obs_q[0][j], exp_q[0][j]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    end_dl();
    start_dl();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_rom_loaded();
    bit early, seen;
    int k;
    clear_log();
    ack_en = 1; ack_dly = 3;
    wr_byte(25'h00200, 8'h01, 1);
    wr_byte(25'h00201, 8'h02, 1);
    ioctl_downl = 1'b0;
    early = 0; seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      tick();
      if (rom_loaded) begin
        seen = 1;
        if (bus.port_req !== bus.port_ack || obs_q[0].size() != exp_q[0].size()) early = 1;
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rom_set: got 0 want 1"); end
    n_cmp++; if (early) begin n_bad++; $display("FAIL rom_early: got set before last ack want after"); end
    k = 0;
    while (core_reset && k < 100) begin
      tick();
      k++;
    end
    n_cmp++; if (k !== HOLD + 1) begin n_bad++; $display("FAIL rom_hold: got %0d cycles want %0d", k, HOLD + 1); end
    ext_reset = 1'b1;
    tick();
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL ext_reset_on: got %b want 1", core_reset); end
    ext_reset = 1'b0;
    tick();
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL ext_reset_off: got %b want 0", core_reset); end
    start_dl();
    n_cmp++; if (rom_loaded !== 1'b0) begin n_bad++; $display("FAIL rom_clear: got %b want 0", rom_loaded); end
  endtask

  task automatic test_reset_mid();
    bit ok, waiting;
    clear_log();
    ack_en = 0;
    wr_byte(25'h00300, 8'h77, 0);
    waiting = 0;
    for (int t = 0; t < 20 && !waiting; t++) begin
      if (bus.port_req !== bus.port_ack) waiting = 1;
      else tick();
    end
    n_cmp++; if (!waiting) begin n_bad++; $display("FAIL mid_wait: got idle want pending request"); end
    reset_n = 1'b0;
    ioctl_downl = 1'b0;
    tick();
    n_cmp++; if (bus.port_req !== 2'b00) begin n_bad++; $display("FAIL mid_req: got %b want 00", bus.port_req); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL mid_core_reset: got %b want 1", core_reset); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (bus.port_we !== 2'b00) begin n_bad++; $display("FAIL mid_empty: got we=%b want 00", bus.port_we); end
    clear_log();
    ack_en = 1; ack_dly = 2;
    start_dl();
    wr_byte(25'h10002, 8'h99, 1);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_drain: got timeout want drained"); end
    for (int i = 0; i < NPORTS; i++) begin
      n_cmp++; if (obs_q[i].size() !== exp_q[i].size()) begin n_bad++; $display("FAIL mid_count p%0d: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      for (int j = 0; j < obs_q[i].size() && j < exp_q[i].size(); j++) begin
        n_cmp++; if (obs_q[i][j] !== exp_q[i][j]) begin n_bad++; $display("FAIL mid_data p%0d[%0d]: got %h want %h", i, j, obs_q[i][j], exp_q[i][j]); end
      end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    logic [15:0] want;
    end_dl();
    clear_log();
    start_dl();
    wr_byte(25'h00400, 8'hFF, 1);
    wr_byte(25'h00401, 8'hFF, 1);
    wr_byte(25'h00402, 8'h03, 1);
    wr_byte(25'h30000, 8'h40, 1);
    wait_drain(ok);
    end_dl();
    repeat (2) tick();
`ifdef DL_ROUTER_CHECKSUM_EN
    want = 16'(exp_sum);
`else
    want = 16'h0000;
`endif
    n_cmp++; if (checksum !== want) begin n_bad++; $display("FAIL checksum: got %h want %h", checksum, want); end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cks_drain: got timeout want drained"); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    ack_en = 1; ack_dly = 3; exp_sum = 0;
    do_reset();
    test_reset();
    test_directed();
    test_regions();
    test_random();
    test_overflow();
    test_rom_loaded();
    test_reset_mid();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
